decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage of the 5-stage MIPS pipeline, directly upstream of the EX stage and fed by the hazard unit.
//  Holds the register file, applies forwarding selects fad/fbd to both source operands and
//  resolves beq equality (eq) in decode. Computes the branch target.
//  Owns the ID/EX pipeline register, which inserts a bubble on a load-use stall.
// PARAMETERS
//  DATA_W     32  datapath / register width
//  ALUCTRL_W  4   width of ALU control field carried to EX
// PORTS
//  clk        in   1          rising-edge clock (single clock domain)
//  rst        in   1          asynchronous, active-high reset
//  instrD     in   32         instruction from IF/ID register
//  pcPlus4D   in   DATA_W     PC+4 from IF/ID register
//  regWriteD, mem2RegD, memWriteD, aluSrcD, regDstD  in 1 each  control from main decoder
//  aluCtrlD   in   ALUCTRL_W  ALU control from ALU decoder
//  stallE     in   1          load-use stall from hazard unit; 1 = insert bubble into EX
//  fad, fbd   in   2          forward select: 0 regfile, 1 aluOutE, 2 readDataM, 3 aluOutM
//  aluOutE    in   DATA_W     ALU result currently in EX
//  aluOutM, readDataM in DATA_W  ALU result / load data in MEM
//  regWriteW  in   1          writeback enable
//  writeRegW  in   5          writeback destination
//  resultW    in   DATA_W     writeback data
//  opcodeD    out  6          instrD[31:26], to hazard unit
//  rsD, rtD   out  5          instrD[25:21], instrD[20:16], to hazard unit
//  eq         out  1          forwarded srcA == forwarded srcB (combinational)
//  branchTargetD out DATA_W   pcPlus4D + (signext(instrD[15:0]) << 2)
//  validE     out  1          EX slot holds a real instruction (0 = bubble)
//  regWriteE, mem2RegE, memWriteE, aluSrcE  out 1 each   registered control
//  aluCtrlE   out  ALUCTRL_W  registered ALU control
//  srcAE, srcBE, immE  out DATA_W  registered forwarded operands / sign-extended imm
//  rsE, rtE   out  5          registered source indices
//  writeRegE  out  5          registered destination: regDstD ? instrD[15:11] : instrD[20:16]
// BEHAVIOUR
//  Register file: 32 x DATA_W; rst clears all entries to 0 asynchronously.
//   Write on posedge clk when regWriteW && writeRegW != 0. Entry 0 always reads 0.
//   Reads are combinational with write-through: if regWriteW && writeRegW == read index != 0,
//   return resultW in the same cycle.
//  Forwarding: srcA = mux(fad) over {regfile[rs], aluOutE, readDataM, aluOutM}; srcB likewise with fbd.
//   eq compares the forwarded values, so a beq depending on an in-flight result resolves in ID.
//  Immediate: sign-extend instrD[15:0] to DATA_W. branchTargetD adds modulo 2^DATA_W (wraps, no flag).
//  ID/EX register (posedge clk, async rst):
//   rst: every output register = 0, so validE=0 and no control bit is asserted.
//   stallE=1: bubble. validE, regWriteE, mem2RegE and memWriteE = 0; all other E fields = 0.
//     The IF/ID hold is the hazard unit's job; this block only kills the EX slot.
//   stallE=0: load all D values and set validE=1. Latency ID->EX is exactly 1 cycle.
//  Simultaneous writeback + read of the same register: write-through value is both forwarded
//   and latched into srcAE/srcBE.
//  rst asserted mid-stream: E outputs clear immediately without waiting for clk. The first edge
//   after deassertion loads the current D inputs.
//  Writes to register 0 are ignored. X-free: all muxes are fully decoded.
// TESTING
//  1 Reset: rst=1 mid-cycle -> all E outputs 0 and validE=0 immediately; reg[5] reads 0 after release.
//  2 Write-through: regWriteW=1, writeRegW=8, resultW=0x1234, rsD=8, fad=0 -> srcA=0x1234 same cycle;
//    srcAE=0x1234 after the edge.
//  3 Forwarding/eq: fad=1 aluOutE=7, fbd=3 aluOutM=7 -> eq=1; change aluOutM to 8 -> eq=0.
//  4 Load-use bubble: stallE=1 with regWriteD=1 -> next edge validE=0 and regWriteE=0;
//    stallE=0 -> next edge validE=1 with D values.
//  5 Reg 0: regWriteW=1, writeRegW=0, resultW=0xFFFF_FFFF -> rs=0 still reads 0.
//  6 Branch target: pcPlus4D=0x100, imm=0xFFFF -> branchTargetD=0xFC;
//    pcPlus4D=0xFFFF_FFFC, imm=1 -> 0x0 (wrap).

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage with register file, operand forwarding, beq compare,
// branch target and the ID/EX pipeline register (bubble on load-use stall).
module decode_stage #(
    parameter int DATA_W    = 32,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instrD,
    input  logic [DATA_W-1:0]    pcPlus4D,
    input  logic                 regWriteD,
    input  logic                 mem2RegD,
    input  logic                 memWriteD,
    input  logic                 aluSrcD,
    input  logic                 regDstD,
    input  logic [ALUCTRL_W-1:0] aluCtrlD,
    input  logic                 stallE,
    input  logic [1:0]           fad,
    input  logic [1:0]           fbd,
    input  logic [DATA_W-1:0]    aluOutE,
    input  logic [DATA_W-1:0]    aluOutM,
    input  logic [DATA_W-1:0]    readDataM,
    input  logic                 regWriteW,
    input  logic [4:0]           writeRegW,
    input  logic [DATA_W-1:0]    resultW,
    output logic [5:0]           opcodeD,
    output logic [4:0]           rsD,
    output logic [4:0]           rtD,
    output logic                 eq,
    output logic [DATA_W-1:0]    branchTargetD,
    output logic                 validE,
    output logic                 regWriteE,
    output logic                 mem2RegE,
    output logic                 memWriteE,
    output logic                 aluSrcE,
    output logic [ALUCTRL_W-1:0] aluCtrlE,
    output logic [DATA_W-1:0]    srcAE,
    output logic [DATA_W-1:0]    srcBE,
    output logic [DATA_W-1:0]    immE,
    output logic [4:0]           rsE,
    output logic [4:0]           rtE,
    output logic [4:0]           writeRegE
);
    localparam int EW = 5 + ALUCTRL_W + 3 * DATA_W + 15;

    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rf_a, rf_b, src_a, src_b, imm;
    logic [EW-1:0]     e_d, e_q;

    assign opcodeD = instrD[31:26];
    assign rsD     = instrD[25:21];
    assign rtD     = instrD[20:16];

    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        else if (regWriteW && writeRegW != 5'd0)
            rf_q[writeRegW] <= resultW;

    // Write-through lets an instruction in ID see the value being written back this cycle.
    always_comb begin
        rf_a  = (rsD == 5'd0) ? '0 : (regWriteW && writeRegW == rsD) ? resultW : rf_q[rsD];
        rf_b  = (rtD == 5'd0) ? '0 : (regWriteW && writeRegW == rtD) ? resultW : rf_q[rtD];
        src_a = (fad == 2'd0) ? rf_a : (fad == 2'd1) ? aluOutE : (fad == 2'd2) ? readDataM : aluOutM;
        src_b = (fbd == 2'd0) ? rf_b : (fbd == 2'd1) ? aluOutE : (fbd == 2'd2) ? readDataM : aluOutM;
        imm   = {{(DATA_W-16){instrD[15]}}, instrD[15:0]};
    end

    assign eq            = (src_a == src_b);
    assign branchTargetD = pcPlus4D + (imm << 2);

    assign e_d = stallE ? '0 : {1'b1, regWriteD, mem2RegD, memWriteD, aluSrcD, aluCtrlD,
                                src_a, src_b, imm, rsD, rtD,
                                regDstD ? instrD[15:11] : instrD[20:16]};

    always_ff @(posedge clk or posedge rst)
        if (rst) e_q <= '0;
        else     e_q <= e_d;

    assign {validE, regWriteE, mem2RegE, memWriteE, aluSrcE, aluCtrlE,
            srcAE, srcBE, immE, rsE, rtE, writeRegE} = e_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a behavioural model.
module tb_decode_stage;
    localparam int EW = 5 + 4 + 96 + 15;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] instrD, pcPlus4D, aluOutE, aluOutM, readDataM, resultW;
    logic        regWriteD, mem2RegD, memWriteD, aluSrcD, regDstD, stallE, regWriteW;
    logic [3:0]  aluCtrlD;
    logic [1:0]  fad, fbd;
    logic [4:0]  writeRegW;
    logic [5:0]  opcodeD;
    logic [4:0]  rsD, rtD, rsE, rtE, writeRegE;
    logic        eq, validE, regWriteE, mem2RegE, memWriteE, aluSrcE;
    logic [31:0] branchTargetD, srcAE, srcBE, immE;
    logic [3:0]  aluCtrlE;
    logic [EW-1:0] got_e;
    logic [31:0] m_rf [32];
    int errors = 0, checks = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .instrD(instrD), .pcPlus4D(pcPlus4D),
        .regWriteD(regWriteD), .mem2RegD(mem2RegD), .memWriteD(memWriteD),
        .aluSrcD(aluSrcD), .regDstD(regDstD), .aluCtrlD(aluCtrlD), .stallE(stallE),
        .fad(fad), .fbd(fbd), .aluOutE(aluOutE), .aluOutM(aluOutM), .readDataM(readDataM),
        .regWriteW(regWriteW), .writeRegW(writeRegW), .resultW(resultW),
        .opcodeD(opcodeD), .rsD(rsD), .rtD(rtD), .eq(eq), .branchTargetD(branchTargetD),
        .validE(validE), .regWriteE(regWriteE), .mem2RegE(mem2RegE), .memWriteE(memWriteE),
        .aluSrcE(aluSrcE), .aluCtrlE(aluCtrlE), .srcAE(srcAE), .srcBE(srcBE), .immE(immE),
        .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE)
    );

    always #5 clk = ~clk;

    assign got_e = {validE, regWriteE, mem2RegE, memWriteE, aluSrcE, aluCtrlE,
                    srcAE, srcBE, immE, rsE, rtE, writeRegE};

    // Reference register file: architectural state only.
    always @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
        else if (regWriteW && writeRegW != 5'd0)
            m_rf[writeRegW] <= resultW;

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] rd(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (regWriteW && writeRegW == r) return resultW;
        return m_rf[r];
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [4:0] r);
        case (sel)
            2'd0:    return rd(r);
            2'd1:    return aluOutE;
            2'd2:    return readDataM;
            default: return aluOutM;
        endcase
    endfunction

    function automatic logic [EW-1:0] exp_e(input logic [31:0] a, input logic [31:0] b);
        if (stallE) return '0;
        return {1'b1, regWriteD, mem2RegD, memWriteD, aluSrcD, aluCtrlD, a, b,
                sext(instrD[15:0]), instrD[25:21], instrD[20:16],
                regDstD ? instrD[15:11] : instrD[20:16]};
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic idle();
        instrD = 32'd0; pcPlus4D = 32'd0; aluOutE = 32'd0; aluOutM = 32'd0;
        readDataM = 32'd0; resultW = 32'd0; regWriteD = 1'b0; mem2RegD = 1'b0;
        memWriteD = 1'b0; aluSrcD = 1'b0; regDstD = 1'b0; stallE = 1'b0;
        regWriteW = 1'b0; aluCtrlD = 4'd0; fad = 2'd0; fbd = 2'd0; writeRegW = 5'd0;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        repeat (2) cycle();
        checks++;
        if (got_e !== '0) begin errors++; $display("FAIL reset_hold got=%h exp=0", got_e); end
        rst = 1'b0;
        instrD = mk(6'h08, 5'd1, 5'd2, 16'h0042); regWriteD = 1'b1;
        regWriteW = 1'b1; writeRegW = 5'd5; resultW = 32'hAAAA;
        cycle();
        checks++;
        if (validE !== 1'b1) begin errors++; $display("FAIL reset_pre_load validE got=%b exp=1", validE); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (got_e !== '0) begin errors++; $display("FAIL reset_async got=%h exp=0", got_e); end
        @(negedge clk);
        rst = 1'b0;
        idle();
        instrD = mk(6'h04, 5'd5, 5'd0, 16'h0);
        fad = 2'd0; fbd = 2'd1; aluOutE = 32'd0;
        #1;
        checks++;
        if (eq !== 1'b1) begin errors++; $display("FAIL reset_reg5_zero eq got=%b exp=1", eq); end
        aluOutE = 32'hAAAA;
        #1;
        checks++;
        if (eq !== 1'b0) begin errors++; $display("FAIL reset_reg5_not_old eq got=%b exp=0", eq); end
    endtask

    task automatic test_write_through();
        idle();
        regWriteW = 1'b1; writeRegW = 5'd8; resultW = 32'h1234;
        instrD = mk(6'h04, 5'd8, 5'd0, 16'h0);
        fad = 2'd0; fbd = 2'd1; aluOutE = 32'h1234;
        #1;
        checks++;
        if (eq !== 1'b1) begin errors++; $display("FAIL wt_same_cycle eq got=%b exp=1", eq); end
        cycle();
        checks++;
        if (srcAE !== 32'h1234) begin errors++; $display("FAIL wt_srcAE got=%h exp=00001234", srcAE); end
        regWriteW = 1'b0;
        #1;
        checks++;
        if (eq !== 1'b1) begin errors++; $display("FAIL wt_stored eq got=%b exp=1", eq); end
    endtask

    task automatic test_forward_eq();
        idle();
        fad = 2'd1; aluOutE = 32'd7; fbd = 2'd3; aluOutM = 32'd7;
        #1;
        checks++;
        if (eq !== 1'b1) begin errors++; $display("FAIL fwd_eq_true got=%b exp=1", eq); end
        aluOutM = 32'd8;
        #1;
        checks++;
        if (eq !== 1'b0) begin errors++; $display("FAIL fwd_eq_false got=%b exp=0", eq); end
        fad = 2'd2; readDataM = 32'd8;
        #1;
        checks++;
        if (eq !== 1'b1) begin errors++; $display("FAIL fwd_readDataM got=%b exp=1", eq); end
        cycle();
        checks++;
        if ({srcAE, srcBE} !== {32'd8, 32'd8}) begin
            errors++; $display("FAIL fwd_latched got=%h/%h exp=8/8", srcAE, srcBE);
        end
    endtask

    task automatic test_stall();
        idle();
        instrD = mk(6'h23, 5'd3, 5'd4, 16'h1234); regWriteD = 1'b1; mem2RegD = 1'b1;
        stallE = 1'b1;
        cycle();
        checks++;
        if (validE !== 1'b0) begin errors++; $display("FAIL stall_validE got=%b exp=0", validE); end
        checks++;
        if (regWriteE !== 1'b0) begin errors++; $display("FAIL stall_regWriteE got=%b exp=0", regWriteE); end
        checks++;
        if (got_e !== '0) begin errors++; $display("FAIL stall_bubble got=%h exp=0", got_e); end
        stallE = 1'b0;
        cycle();
        checks++;
        if ({validE, regWriteE, mem2RegE} !== 3'b111) begin
            errors++; $display("FAIL stall_release ctl got=%b exp=111", {validE, regWriteE, mem2RegE});
        end
        checks++;
        if ({rtE, immE, writeRegE} !== {5'd4, 32'h1234, 5'd4}) begin
            errors++; $display("FAIL stall_release data got=%h/%h/%h exp=4/1234/4", rtE, immE, writeRegE);
        end
    endtask

    task automatic test_reg0();
        idle();
        regWriteW = 1'b1; writeRegW = 5'd0; resultW = 32'hFFFF_FFFF;
        instrD = mk(6'h04, 5'd0, 5'd0, 16'h0);
        fad = 2'd0; fbd = 2'd1; aluOutE = 32'd0;
        #1;
        checks++;
        if (eq !== 1'b1) begin errors++; $display("FAIL reg0_same_cycle eq got=%b exp=1", eq); end
        cycle();
        regWriteW = 1'b0;
        #1;
        checks++;
        if (eq !== 1'b1) begin errors++; $display("FAIL reg0_after eq got=%b exp=1", eq); end
        checks++;
        if (srcAE !== 32'd0) begin errors++; $display("FAIL reg0_srcAE got=%h exp=0", srcAE); end
    endtask

    task automatic test_branch();
        idle();
        pcPlus4D = 32'h100; instrD = mk(6'h04, 5'd0, 5'd0, 16'hFFFF);
        #1;
        checks++;
        if (branchTargetD !== 32'hFC) begin errors++; $display("FAIL br_neg got=%h exp=000000fc", branchTargetD); end
        pcPlus4D = 32'hFFFF_FFFC; instrD = mk(6'h04, 5'd0, 5'd0, 16'h0001);
        #1;
        checks++;
        if (branchTargetD !== 32'h0) begin errors++; $display("FAIL br_wrap got=%h exp=0", branchTargetD); end
        checks++;
        if ({opcodeD, rsD, rtD} !== {6'h04, 5'd0, 5'd0}) begin
            errors++; $display("FAIL br_fields got=%h/%h/%h exp=4/0/0", opcodeD, rsD, rtD);
        end
        cycle();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [EW-1:0] e;
        for (int n = 0; n < 300; n++) begin
            instrD = $urandom; pcPlus4D = $urandom; aluCtrlD = 4'($urandom);
            {regWriteD, mem2RegD, memWriteD, aluSrcD, regDstD} = 5'($urandom);
            stallE = ($urandom_range(3) == 0);
            fad = 2'($urandom); fbd = ($urandom_range(3) == 0) ? fad : 2'($urandom);
            aluOutE = $urandom; aluOutM = $urandom; readDataM = $urandom; resultW = $urandom;
            regWriteW = 1'($urandom);
            writeRegW = $urandom_range(1) ? instrD[25:21] : 5'($urandom);
            #1;
            a = fwd(fad, instrD[25:21]);
            b = fwd(fbd, instrD[20:16]);
            checks++;
            if (eq !== (a == b)) begin errors++; $display("FAIL rnd_eq[%0d] got=%b exp=%b", n, eq, a == b); end
            checks++;
            if (branchTargetD !== pcPlus4D + sext(instrD[15:0]) * 32'd4) begin
                errors++; $display("FAIL rnd_br[%0d] got=%h exp=%h", n, branchTargetD, pcPlus4D + sext(instrD[15:0]) * 32'd4);
            end
            e = exp_e(a, b);
            cycle();
            checks++;
            if (got_e !== e) begin errors++; $display("FAIL rnd_e[%0d] got=%h exp=%h", n, got_e, e); end
        end
    endtask

    initial begin
        test_reset();
        test_write_through();
        test_forward_eq();
        test_stall();
        test_reg0();
        test_branch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
